// File: rtl/sqrt_ctrl.sv
// ---------------------------------------------------------------------------
// sqrt_ctrl
// Sequencing controller for the structural integer square-root datapath.
// It computes root = floor(sqrt(N)) for an 8-bit radicand by repeatedly
// subtracting the odd numbers 1, 3, 5, ... until the one-hot ALU reports a
// borrow. The number of subtractions taken is the root.
//
// Ports
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   start      in   1  request; sampled only in IDLE
//   n_in       in   8  radicand, captured on the accept edge
//   busy       out  1  high in every state except IDLE
//   done       out  1  one-cycle pulse in DONE
//   root       out  8  result, updated on the edge leaving DONE
//   alu_fnsel  out  7  one-hot ALU function select
//   alu_x      out  8  ALU operand x
//   alu_y      out  8  ALU operand y
//   alu_z      in   8  combinational ALU result
//   alu_bo     in   1  ALU borrow from x - y
// ---------------------------------------------------------------------------
module sqrt_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] n_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] root,
  output logic [6:0] alu_fnsel,
  output logic [7:0] alu_x,
  output logic [7:0] alu_y,
  input  logic [7:0] alu_z,
  input  logic       alu_bo
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_INIT_D = 3'd2,
    S_INIT_Q = 3'd3,
    S_SUB    = 3'd4,
    S_INCQ   = 3'd5,
    S_INCD   = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  localparam logic [6:0] FN_PASS_X = 7'b0000001;
  localparam logic [6:0] FN_ZERO   = 7'b0000010;
  localparam logic [6:0] FN_ONE    = 7'b0000100;
  localparam logic [6:0] FN_SUB    = 7'b0001000;
  localparam logic [6:0] FN_INC_Y  = 7'b0010000;
  localparam logic [6:0] FN_ADD2_X = 7'b0100000;

  state_t     state_q, state_d;
  logic [7:0] nreg_q, nreg_d;
  logic [7:0] r_q, r_d;
  logic [7:0] d_q, d_d;
  logic [7:0] q_q, q_d;
  logic [7:0] root_q, root_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [6:0] fnsel_q, fnsel_d;
  logic [7:0] x_q, x_d;
  logic [7:0] y_q, y_d;

  // Next-state and working-register updates. alu_z / alu_bo are consumed
  // here in the same cycle the matching fnsel is presented.
  always_comb begin
    state_d = state_q;
    nreg_d  = nreg_q;
    r_d     = r_q;
    d_d     = d_q;
    q_d     = q_q;
    root_d  = root_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          nreg_d  = n_in;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        r_d     = alu_z;
        state_d = S_INIT_D;
      end
      S_INIT_D: begin
        d_d     = alu_z;
        state_d = S_INIT_Q;
      end
      S_INIT_Q: begin
        q_d     = alu_z;
        state_d = S_SUB;
      end
      S_SUB: begin
        // Borrow means the remainder can no longer absorb the next odd
        // number; R is left untouched on that path.
        if (alu_bo) begin
          state_d = S_DONE;
        end else begin
          r_d     = alu_z;
          state_d = S_INCQ;
        end
      end
      S_INCQ: begin
        q_d     = alu_z;
        state_d = S_INCD;
      end
      S_INCD: begin
        d_d     = alu_z;
        state_d = S_SUB;
      end
      S_DONE: begin
        root_d  = q_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode is computed from the *next* state and register values so
  // the registered outputs line up with the state they describe and never
  // depend combinationally on the ALU return path.
  always_comb begin
    fnsel_d = '0;
    x_d     = '0;
    y_d     = '0;
    case (state_d)
      S_LOAD:   begin fnsel_d = FN_PASS_X; x_d = nreg_d; end
      S_INIT_D: fnsel_d = FN_ONE;
      S_INIT_Q: fnsel_d = FN_ZERO;
      S_SUB:    begin fnsel_d = FN_SUB; x_d = r_d; y_d = d_d; end
      S_INCQ:   begin fnsel_d = FN_INC_Y; y_d = q_d; end
      S_INCD:   begin fnsel_d = FN_ADD2_X; x_d = d_d; end
      default:  fnsel_d = '0;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      nreg_q  <= '0;
      r_q     <= '0;
      d_q     <= '0;
      q_q     <= '0;
      root_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fnsel_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      nreg_q  <= nreg_d;
      r_q     <= r_d;
      d_q     <= d_d;
      q_q     <= q_d;
      root_q  <= root_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fnsel_q <= fnsel_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign root      = root_q;
  assign alu_fnsel = fnsel_q;
  assign alu_x     = x_q;
  assign alu_y     = y_q;

endmodule

// File: tb/tb_sqrt_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sqrt_ctrl
// Self-checking bench for sqrt_ctrl with a behavioural one-hot ALU attached.
// Expected roots and latencies come from plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_sqrt_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] n_in;
  logic       busy;
  logic       done;
  logic [7:0] root;
  logic [6:0] alu_fnsel;
  logic [7:0] alu_x;
  logic [7:0] alu_y;
  logic [7:0] alu_z;
  logic       alu_bo;

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] fn_trace [0:7];
  logic [7:0] sub_x, sub_y;
  logic       sub_bo;

  always #5 clk = ~clk;

  sqrt_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .n_in      (n_in),
    .busy      (busy),
    .done      (done),
    .root      (root),
    .alu_fnsel (alu_fnsel),
    .alu_x     (alu_x),
    .alu_y     (alu_y),
    .alu_z     (alu_z),
    .alu_bo    (alu_bo)
  );

  // Behavioural one-hot ALU. With no function selected the result is a
  // recognisable junk value so that any stray sampling shows up.
  always_comb begin
    alu_z  = 8'h5A;
    alu_bo = 1'b0;
    case (alu_fnsel)
      7'b0000001: alu_z = alu_x;
      7'b0000010: alu_z = 8'd0;
      7'b0000100: alu_z = 8'd1;
      7'b0001000: {alu_bo, alu_z} = {1'b0, alu_x} - {1'b0, alu_y};
      7'b0010000: alu_z = 8'(alu_y + 8'd1);
      7'b0100000: alu_z = 8'(alu_x + 8'd2);
      7'b1000000: alu_z = 8'(alu_x + alu_y);
      default:    alu_z = 8'h5A;
    endcase
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_root(input int n);
    int k = 0;
    while ((k + 1) * (k + 1) <= n) k++;
    return k;
  endfunction

  // One request. mid_cyc >= 0 re-asserts start that many cycles after the
  // accept edge; poke_done asserts start during the DONE cycle.
  task automatic do_sqrt(input logic [7:0] n, input int mid_cyc,
                         input logic [7:0] mid_n, input bit poke_done);
    int k, e, bad;
    k   = ref_root(int'(n));
    e   = 0;
    bad = 0;
    @(negedge clk);
    start = 1'b1;
    n_in  = n;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_in  = 8'($urandom);
    while (e <= 200) begin
      if (e < 8) fn_trace[e] = alu_fnsel;
      if (done) break;
      if (!busy || !$onehot(alu_fnsel)) bad++;
      if (alu_fnsel == 7'b0001000) begin
        sub_x  = alu_x;
        sub_y  = alu_y;
        sub_bo = alu_bo;
      end
      if (e == mid_cyc) begin
        start = 1'b1;
        n_in  = mid_n;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      e++;
    end
    start = 1'b0;
    check($sformatf("latency_n%0d", n), e, 3 * k + 4);
    check("done_fnsel_zero", int'(alu_fnsel), 0);
    if (poke_done) begin
      start = 1'b1;
      n_in  = 8'($urandom);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    check($sformatf("root_n%0d", n), int'(root), k);
    check("busy_after_done", int'(busy), 0);
    check("done_one_cycle", int'(done), 0);
    check("onehot_busy", bad, 0);
  endtask

  initial begin
    logic [7:0] perm [0:255];
    logic [7:0] tmp;
    int j;
    bit found;

    rst_n = 1'b0;
    start = 1'b0;
    n_in  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  int'(busy), 0);
    check("rst_done",  int'(done), 0);
    check("rst_root",  int'(root), 0);
    check("rst_fnsel", int'(alu_fnsel), 0);
    check("rst_x",     int'(alu_x), 0);
    check("rst_y",     int'(alu_y), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", int'(busy), 0);

    // N=0: latency and full fnsel trace.
    do_sqrt(8'd0, -1, 8'd0, 1'b0);
    check("trace0", int'(fn_trace[0]), 7'b0000001);
    check("trace1", int'(fn_trace[1]), 7'b0000100);
    check("trace2", int'(fn_trace[2]), 7'b0000010);
    check("trace3", int'(fn_trace[3]), 7'b0001000);
    check("trace4", int'(fn_trace[4]), 7'b0000000);

    do_sqrt(8'd1,  -1, 8'd0, 1'b0);
    do_sqrt(8'd4,  -1, 8'd0, 1'b0);
    do_sqrt(8'd15, -1, 8'd0, 1'b0);
    do_sqrt(8'd16, -1, 8'd0, 1'b0);

    // Largest radicand and its final borrowing subtraction.
    do_sqrt(8'd255, -1, 8'd0, 1'b0);
    check("final_sub_x",  int'(sub_x), 30);
    check("final_sub_y",  int'(sub_y), 31);
    check("final_sub_bo", int'(sub_bo), 1);

    // Start during computation and during DONE must be ignored.
    do_sqrt(8'd100, 10, 8'd37, 1'b1);

    // Exhaustive sweep in random order with random gaps and pokes.
    for (int i = 0; i < 256; i++) perm[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp     = perm[i];
      perm[i] = perm[j];
      perm[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      do_sqrt(perm[i], int'($urandom_range(0, 60)), 8'($urandom),
              1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a computation.
    @(negedge clk);
    start = 1'b1;
    n_in  = 8'd200;
    @(posedge clk);
    #1;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (alu_fnsel == 7'b0010000) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("rst_wait_incq", int'(found), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  int'(busy), 0);
    check("mid_rst_done",  int'(done), 0);
    check("mid_rst_root",  int'(root), 0);
    check("mid_rst_fnsel", int'(alu_fnsel), 0);
    check("mid_rst_x",     int'(alu_x), 0);
    check("mid_rst_y",     int'(alu_y), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle", int'(busy), 0);
    do_sqrt(8'd49, -1, 8'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sqrt_ctrl.md
# sqrt_ctrl

Sequencing controller for the structural integer square-root datapath. It sits directly upstream of the one-hot function-select ALU and drives that ALU's `fnsel`, `x` and `y` inputs. It consumes the ALU's `z` result and `bo` borrow flag, and holds the working registers. It computes `root = floor(sqrt(N))` for an 8-bit `N` by the odd-number subtraction method, subtracting 1, 3, 5, … until a borrow occurs.

## Interface
- No parameters; all datapath widths are fixed at 8 bits.
- `clk`  in  1  — single clock; all state changes on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `start`  in  1  — request a computation; sampled only in IDLE.
- `n_in`  in  8  — radicand N; captured on the edge that accepts `start`.
- `busy`  out  1  — high in every state except IDLE.
- `done`  out  1  — one-cycle pulse while in DONE.
- `root`  out  8  — result register; holds its value until the next DONE.
- `alu_fnsel`  out  7  — one-hot ALU select.
  - bit0: z=x; bit1: z=0; bit2: z=1.
  - bit3: {bo,z}=x−y; bit4: z=y+1; bit5: z=x+2; bit6: z=x+y (unused).
- `alu_x`  out  8  — ALU operand x.
- `alu_y`  out  8  — ALU operand y.
- `alu_z`  in  8  — ALU result; combinational, so it is valid in the same cycle as `alu_fnsel`.
- `alu_bo`  in  1  — borrow from x−y; 1 iff x<y unsigned. Meaningful only when `alu_fnsel[3]`=1.

## Operation
- Internal registers: `nreg`, `R` (remainder), `D` (current odd number), `Q` (count), all 8 bits.
- States and actions per cycle (`alu_fnsel` value in brackets; operands not listed drive 0):
  - IDLE [0000000]: if `start`, `nreg`←`n_in` and go to LOAD. Otherwise stay.
  - LOAD [0000001], x=`nreg`: `R`←z; go to INIT_D.
  - INIT_D [0000100]: `D`←z (=1); go to INIT_Q.
  - INIT_Q [0000010]: `Q`←z (=0); go to SUB.
  - SUB [0001000], x=`R`, y=`D`:
    - if `alu_bo`=1, leave `R` unchanged and go to DONE;
    - else `R`←z and go to INCQ.
  - INCQ [0010000], y=`Q`: `Q`←z; go to INCD.
  - INCD [0100000], x=`D`: `D`←z; go to SUB.
  - DONE [0000000]: `root`←`Q`, `done`=1; go to IDLE.
- `alu_fnsel` is exactly one-hot in LOAD through INCD and all-zero in IDLE and DONE. The ALU output is undriven when `fnsel` is 0, so `alu_z` is not sampled in those states.
- Width rules: for N≤255, D never exceeds 31 and Q never exceeds 15, so no overflow can occur. Equality R=D gives no borrow, and the subtraction is taken.
- `start` asserted while `busy`=1 is ignored, with no queuing. Changes to `n_in` after the accept edge have no effect.
- Asserting `start` in the DONE cycle is ignored. A new request is accepted from IDLE on the next cycle.
- Reset (asynchronous, any state, including mid-computation):
  - state→IDLE; `nreg`, `R`, `D`, `Q`, `root`←0.
  - `done`=0, `busy`=0, `alu_fnsel`=0, `alu_x`=0, `alu_y`=0.
  - Computation restarts only on a fresh `start` after `rst_n` deasserts.

## Timing
- All outputs are registered state decodes or register values. `alu_x`, `alu_y` and `alu_fnsel` are decoded from the current state and registers only, never from `alu_z` or `alu_bo`.
- For result k=floor(sqrt(N)), the state sequence after accept is LOAD, INIT_D, INIT_Q, then k×(SUB, INCQ, INCD), then SUB(borrow), then DONE.
- `done` is high in the cycle beginning 3k+4 rising edges after the accept edge:
  - N=0: done on the 4th edge after accept.
  - N=255: done on the 49th edge after accept.
- `root` updates on the edge that leaves DONE. It therefore reads the new value starting in the first IDLE cycle after the `done` pulse.
- `busy` rises on the accept edge and falls on the edge leaving DONE.
- Minimum start-to-start spacing is 3k+6 cycles.

## Test plan
- Reset, then drive `start` with N=0 → `done` on edge 4 after accept; `root`=0. The `alu_fnsel` trace must be 0000001, 0000100, 0000010, 0001000, then 0.
- N=1, N=4, N=15, N=16 → `root` = 1, 2, 3, 4; `done` at edges 7, 10, 13, 16 after accept.
- N=255 → `root`=15; `done` at edge 49. In the final SUB, x=30 and y=31, and `alu_bo`=1.
- Exhaustive sweep N=0..255 with the ALU model attached → `root`=floor(sqrt(N)) every time. `alu_fnsel` is one-hot in every busy non-DONE cycle.
- Assert `start` with a different `n_in` mid-computation (N=100, 10 cycles in) → ignored; `root`=10 for the original N=100.
- Assert `rst_n`=0 during INCQ of N=200, then release → all outputs 0 immediately. A following N=49 request yields `root`=7 with normal latency (25 edges).
